// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster timing generator with PLL lock qualification
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_SETTLE = 1024,
  parameter int CW          = 10
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SW      = $clog2(LOCK_SETTLE);

  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t        state;
  logic          lock_meta;
  logic          lock_s;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          h_act;
  logic          v_act;

  assign h_act = (hcnt < H_ACT_C);
  assign v_act = (vcnt < V_ACT_C);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= locked;
      lock_s    <= lock_meta;
    end
  end

  // Outputs default to idle every cycle and are only decoded while RUN is
  // both current and continuing, so a lock drop idles them on the same edge
  // that leaves RUN.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_LOCK;
      settle_cnt  <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
      case (state)
        WAIT_LOCK: begin
          settle_cnt <= '0;
          hcnt       <= '0;
          vcnt       <= '0;
          if (lock_s) begin
            // this lock_s=1 cycle is the first one counted
            state      <= SETTLE;
            settle_cnt <= SW'(1);
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state      <= RUN;
            settle_cnt <= '0;
            hcnt       <= '0;
            vcnt       <= '0;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            hcnt  <= '0;
            vcnt  <= '0;
          end else begin
            if (hcnt == H_LAST) begin
              hcnt <= '0;
              vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
            end else begin
              hcnt <= hcnt + CW'(1);
            end
            de          <= h_act && v_act;
            hsync       <= ((hcnt >= HS_START) && (hcnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync       <= ((vcnt >= VS_START) && (vcnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
            x           <= (h_act && v_act) ? hcnt : '0;
            y           <= (h_act && v_act) ? vcnt : '0;
            line_start  <= (hcnt == '0) && v_act;
            frame_start <= (hcnt == '0) && (vcnt == '0);
            running     <= 1'b1;
          end
        end
        default: begin
          state <= WAIT_LOCK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen (full line, short frame)
module tb_vga_timing_gen;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 24, VF = 3, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       hsync, vsync, de, line_start, frame_start, running;
  logic [9:0] x, y;

  int total = 0;
  int bad = 0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .LOCK_SETTLE(8), .CW(10)
  ) dut (
    .refclk(clk), .rst(rst), .locked(locked),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .running(running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_running(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (running) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hsync"}, hsync, 1);
    check({tag, "_vsync"}, vsync, 1);
    check({tag, "_de"}, de, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_ls"}, line_start, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_run"}, running, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hc, vc;
    int e_de, e_hs, e_vs, e_x, e_y, e_ls, e_fs;
    int err_de, err_hs, err_vs, err_xy, err_ls, err_fs;
    int de_cnt, ls_cnt, hs_first, hs_cnt, vs_first, vs_cnt, fs_next, max_x, max_y;
    int early;

    rst = 1'b1;
    locked = 1'b0;
    step(3);
    check_idle("reset");
    rst = 1'b0;
    step(3);
    check("unlocked_run", running, 0);

    // lock qualification
    locked = 1'b1;
    wait_running(n);
    check("lock_latency", n, LAT);
    check("first_fs", frame_start, 1);
    check("first_ls", line_start, 1);
    check("first_de", de, 1);
    check("first_x", x, 0);
    check("first_y", y, 0);

    // one full frame against a per-cycle reference, plus measured aggregates
    err_de = 0; err_hs = 0; err_vs = 0; err_xy = 0; err_ls = 0; err_fs = 0;
    de_cnt = 0; ls_cnt = 0; hs_first = -1; hs_cnt = 0; vs_first = -1; vs_cnt = 0;
    fs_next = -1; max_x = 0; max_y = 0;
    for (int c = 0; c <= FRAME; c++) begin
      if (c > 0) @(negedge clk);
      hc = c % HT;
      vc = (c / HT) % VT;
      e_de = (hc < HA && vc < VA) ? 1 : 0;
      e_hs = (hc >= HA + HF && hc < HA + HF + HS) ? 0 : 1;
      e_vs = (vc >= VA + VF && vc < VA + VF + VS) ? 0 : 1;
      e_x  = e_de ? hc : 0;
      e_y  = e_de ? vc : 0;
      e_ls = (hc == 0 && vc < VA) ? 1 : 0;
      e_fs = (hc == 0 && vc == 0) ? 1 : 0;
      if (de !== e_de[0]) err_de++;
      if (hsync !== e_hs[0]) err_hs++;
      if (vsync !== e_vs[0]) err_vs++;
      if (x !== e_x[9:0] || y !== e_y[9:0]) err_xy++;
      if (line_start !== e_ls[0]) err_ls++;
      if (frame_start !== e_fs[0]) err_fs++;
      if (c < FRAME) begin
        if (de) de_cnt++;
        if (line_start) ls_cnt++;
        if (!hsync) hs_cnt++;
        if (!hsync && hs_first < 0) hs_first = c;
        if (!vsync) vs_cnt++;
        if (!vsync && vs_first < 0) vs_first = c;
        if (de && int'(x) > max_x) max_x = int'(x);
        if (de && int'(y) > max_y) max_y = int'(y);
      end
      if (c > 0 && frame_start && fs_next < 0) fs_next = c;
    end
    check("trk_de", err_de, 0);
    check("trk_hsync", err_hs, 0);
    check("trk_vsync", err_vs, 0);
    check("trk_xy", err_xy, 0);
    check("trk_ls", err_ls, 0);
    check("trk_fs", err_fs, 0);
    check("de_count", de_cnt, 640 * 24);
    check("ls_count", ls_cnt, 24);
    check("hs_first", hs_first, 656);
    check("hs_count", hs_cnt, 96 * 33);
    check("vs_first", vs_first, 27 * 800);
    check("vs_count", vs_cnt, 1600);
    check("fs_period", fs_next, 26400);
    check("max_x", max_x, 639);
    check("max_y", max_y, 23);

    // lock loss mid-frame at line 10
    step(10 * HT + 100);
    check("mid_run", running, 1);
    check("mid_x", x, 100);
    check("mid_y", y, 10);
    locked = 1'b0;
    step(2);
    check("drop_still_run", running, 1);
    step(1);
    check_idle("drop");
    step(4);
    locked = 1'b1;
    wait_running(n);
    check("relock_latency", n, LAT);
    check("relock_fs", frame_start, 1);
    check("relock_x", x, 0);
    check("relock_y", y, 0);
    check("relock_de", de, 1);

    // one-cycle glitch while settling restarts qualification
    locked = 1'b0;
    step(4);
    check("glitch_pre_idle", running, 0);
    locked = 1'b1;
    early = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (running) early++;
    end
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    wait_running(n);
    check("glitch_early", early, 0);
    check("glitch_latency", n, LAT);

    // asynchronous reset during active video
    step(4);
    check("pre_rst_de", de, 1);
    check("pre_rst_x", x, 4);
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    rst = 1'b0;
    wait_running(n);
    check("post_rst_latency", n, LAT);
    check("post_rst_fs", frame_start, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
